// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: channel width, colour word layout
// and the PWM full-scale constant.
package rgb_pwm_driver_pkg;

  localparam int unsigned CH_W     = 8;
  localparam int unsigned COLOUR_W = 3 * CH_W;

  // Field offsets inside the packed {R,G,B} colour word.
  localparam int unsigned R_OFS = 2 * CH_W;
  localparam int unsigned G_OFS = CH_W;
  localparam int unsigned B_OFS = 0;

  // Full-scale duty; the period counter tops out one below it, so a duty of
  // PWM_MAX keeps the output high for the whole period.
  localparam logic [CH_W-1:0] PWM_MAX = {CH_W{1'b1}};
  localparam logic [CH_W-1:0] CNT_MAX = PWM_MAX - 1'b1;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } colour_t;

  // Split a packed colour word into its three channels.
  function automatic colour_t unpack_colour(input logic [COLOUR_W-1:0] word);
    colour_t c;
    c.r = word[R_OFS +: CH_W];
    c.g = word[G_OFS +: CH_W];
    c.b = word[B_OFS +: CH_W];
    return c;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output: compares the shared period count against this channel's
// duty and registers the result.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [CH_W-1:0] cnt,
  input  logic [CH_W-1:0] duty,
  output logic            pwm
);

  // Drive high while the period count is below the duty; forced low when idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= run && (cnt < duty);
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: buffers one pending colour behind a valid/ready
// handshake and applies it to the three PWM channels only at period
// boundaries, so the LED never shows a torn colour.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sys_on,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                colour_valid,
  output logic                colour_ready,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                period_start
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic            sys_on_q;
  logic            run;
  logic            tick;
  logic            boundary;
  logic            take;
  logic [PS_W-1:0] ps_cnt;
  logic [CH_W-1:0] cnt;
  logic            pending_full;
  colour_t         pending;
  colour_t         active;

  // The cycle sys_on rises is spent announcing the new period, so counting
  // begins at cnt=0 on the cycle period_start is high.
  assign run          = sys_on && sys_on_q;
  assign tick         = run && (ps_cnt == PS_LAST);
  assign boundary     = tick && (cnt == CNT_MAX);
  assign colour_ready = !pending_full;
  assign take         = colour_valid && colour_ready;

  // Remember sys_on to detect the off->on transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sys_on_q <= 1'b0;
    else        sys_on_q <= sys_on;
  end

  // Prescaler: 0..PRESCALE-1, held at 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ps_cnt <= '0;
    else if (!run || tick)  ps_cnt <= '0;
    else                    ps_cnt <= ps_cnt + 1'b1;
  end

  // Period counter: advances per tick over 0..CNT_MAX, held at 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (!run)  cnt <= '0;
    else if (tick)  cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  end

  // Flag the first cycle of each period, including the one started by sys_on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_start <= 1'b0;
    else        period_start <= (sys_on && !sys_on_q) || boundary;
  end

  // Pending/active colour buffers: a boundary moves pending into active; new
  // words only ever land in pending, never straight into active.
  // NOTE: the colour data registers are reset as well as the full flag, so a
  // boundary can never copy an uninitialised word into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      pending      <= '0;
      active       <= '0;
    end else if (boundary && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (take) begin
      pending      <= unpack_colour(colour_in);
      pending_full <= 1'b1;
    end
  end

  pwm_channel u_ch_r (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .cnt   (cnt),
    .duty  (active.r),
    .pwm   (pwm_r)
  );

  pwm_channel u_ch_g (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .cnt   (cnt),
    .duty  (active.g),
    .pwm   (pwm_g)
  );

  pwm_channel u_ch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .cnt   (cnt),
    .duty  (active.b),
    .pwm   (pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=1 for duty and
// handshake checks, one at PRESCALE=4 for period spacing and tick alignment.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys_on, sys_on4;
  logic [23:0] colour_in;
  logic        valid, valid4;
  logic        ready1, r1, g1, b1, ps1;
  logic        ready4, r4, g4, b4, ps4;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Per-period accumulators, sampled once per clk after the rising edge.
  int n_cyc, h_r1, h_g1, h_b1, n_rdy1, n_ps1, first_r1, last_high_r1;
  int h_r4, h_g4, h_b4, last_high_g4;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sys_on       (sys_on),
    .colour_in    (colour_in),
    .colour_valid (valid),
    .colour_ready (ready1),
    .pwm_r        (r1),
    .pwm_g        (g1),
    .pwm_b        (b1),
    .period_start (ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sys_on       (sys_on4),
    .colour_in    (colour_in),
    .colour_valid (valid4),
    .colour_ready (ready4),
    .pwm_r        (r4),
    .pwm_g        (g4),
    .pwm_b        (b4),
    .period_start (ps4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    n_cyc = 0; h_r1 = 0; h_g1 = 0; h_b1 = 0; n_rdy1 = 0; n_ps1 = 0;
    first_r1 = 0; last_high_r1 = 0;
    h_r4 = 0; h_g4 = 0; h_b4 = 0; last_high_g4 = 0;
  endtask

  task automatic step_acc();
    step();
    n_cyc++;
    h_r1 += int'(r1); h_g1 += int'(g1); h_b1 += int'(b1);
    n_rdy1 += int'(ready1); n_ps1 += int'(ps1);
    if (n_cyc == 1) first_r1 = int'(r1);
    if (r1) last_high_r1 = n_cyc;
    h_r4 += int'(r4); h_g4 += int'(g4); h_b4 += int'(b4);
    if (g4) last_high_g4 = n_cyc;
  endtask

  // Step until the selected instance pulses period_start, bounded by budget.
  task automatic run_to_ps(input bit sel4, input int budget);
    bit hit = 1'b0;
    while (!hit && n_cyc < budget) begin
      step_acc();
      hit = sel4 ? ps4 : ps1;
    end
  endtask

  initial begin
    rst_n = 1'b0; sys_on = 1'b0; sys_on4 = 1'b0;
    valid = 1'b0; valid4 = 1'b0; colour_in = 24'h0;

    // Reset state
    repeat (3) step();
    check("rst_ready1", ready1, 1);
    check("rst_ready4", ready4, 1);
    check("rst_pwm1", {r1, g1, b1}, 3'b000);
    check("rst_ps1", ps1, 0);
    rst_n = 1'b1;
    step();

    // Buffer 0xFF8000 into both instances while idle
    colour_in = 24'hFF8000; valid = 1'b1; valid4 = 1'b1;
    step();
    valid = 1'b0; valid4 = 1'b0;
    check("load_ready1", ready1, 0);
    check("load_ready4", ready4, 0);

    // Start u1: first period runs on the retained (zero) active colour
    sys_on = 1'b1;
    step();
    check("rise_ps1", ps1, 1);
    clear_acc();
    run_to_ps(1'b0, 300);
    check("p1_len", n_cyc, 255);
    check("p1_r", h_r1, 0);
    check("p1_rdy_cnt", n_rdy1, 1);
    check("p1_ready_end", ready1, 1);

    // Period of 0xFF8000; load 0x000010 at its start, then offer 0x404040
    clear_acc();
    colour_in = 24'h000010; valid = 1'b1;
    step_acc();
    colour_in = 24'h404040;
    check("p2_ready_low", ready1, 0);
    run_to_ps(1'b0, 300);
    check("p2_len", n_cyc, 255);
    check("p2_r", h_r1, 255);
    check("p2_g", h_g1, 128);
    check("p2_b", h_b1, 0);
    check("p2_rdy_cnt", n_rdy1, 1);
    check("p2_ready_end", ready1, 1);

    // Held-off word is accepted the cycle after the boundary load
    clear_acc();
    step_acc();
    valid = 1'b0;
    check("p3_second_taken", ready1, 0);
    run_to_ps(1'b0, 300);
    check("p3_len", n_cyc, 255);
    check("p3_r", h_r1, 0);
    check("p3_g", h_g1, 0);
    check("p3_b", h_b1, 16);
    check("p3_ready_end", ready1, 1);

    // sys_on low for 100 clks with active = 0x404040
    sys_on = 1'b0;
    clear_acc();
    repeat (100) step_acc();
    check("off_r", h_r1, 0);
    check("off_g", h_g1, 0);
    check("off_b", h_b1, 0);
    check("off_ps", n_ps1, 0);
    check("off_ready", ready1, 1);

    // sys_on back high: immediate period start, 64-tick pulses from cnt=0
    sys_on = 1'b1;
    step();
    check("on_ps1", ps1, 1);
    clear_acc();
    run_to_ps(1'b0, 300);
    check("on_len", n_cyc, 255);
    check("on_r", h_r1, 64);
    check("on_g", h_g1, 64);
    check("on_b", h_b1, 64);
    check("on_first_r", first_r1, 1);
    check("on_last_high_r", last_high_r1, 64);

    // PRESCALE=4: 1020-clk periods, pwm edges on tick boundaries
    sys_on4 = 1'b1;
    step();
    check("rise_ps4", ps4, 1);
    clear_acc();
    run_to_ps(1'b1, 1100);
    check("p4a_len", n_cyc, 1020);
    check("p4a_r", h_r4, 0);
    clear_acc();
    run_to_ps(1'b1, 1100);
    check("p4b_len", n_cyc, 1020);
    check("p4b_r", h_r4, 1020);
    check("p4b_g", h_g4, 512);
    check("p4b_b", h_b4, 0);
    check("p4b_last_high_g", last_high_g4, 512);

    // Asynchronous reset mid-period with pending full and pwm high
    clear_acc();
    run_to_ps(1'b0, 300);
    repeat (5) step();
    colour_in = 24'h123456; valid = 1'b1;
    step();
    valid = 1'b0;
    check("pre_rst_ready", ready1, 0);
    check("pre_rst_r1", r1, 1);
    check("pre_rst_r4", r4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pwm1", {r1, g1, b1}, 3'b000);
    check("async_ready1", ready1, 1);
    check("async_r4", r4, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ps1", ps1, 1);
    clear_acc();
    run_to_ps(1'b0, 300);
    check("post_rst_len", n_cyc, 255);
    check("post_rst_r", h_r1, 0);
    check("post_rst_g", h_g1, 0);
    check("post_rst_rdy_cnt", n_rdy1, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
